// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types, geometry constants and helpers for the L1 cache controller
package cache_types_pkg;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } cache_state_t;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;

  function automatic logic [31:0] line_align(input logic [31:0] addr, input int off);
    line_align = addr & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// rtl/cache_control_sat_counter.sv - saturating event counter for cache performance monitoring
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {width{1'b1}})) begin
      count_d = count_q + width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - control FSM for the direct-mapped write-back L1 cache
module cache_control
  import cache_types_pkg::*;
#(
  parameter int s_offset  = S_OFFSET,
  parameter int s_index   = S_INDEX,
  parameter int s_tag     = 32 - s_offset - s_index,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [31:0]          cpu_address,
  output logic                 cpu_resp,
  output logic                 array_read,
  output logic [s_index-1:0]   array_index,
  input  logic [s_tag-1:0]     tag_out,
  input  logic                 valid_out,
  input  logic                 dirty_out,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 data_load,
  output logic                 data_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  input  logic                 pmem_resp,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  cache_state_t state_d, state_q;
  logic refill_d, refill_q;
  logic hit_inc, miss_inc;
  logic req, hit;
  logic [s_tag-1:0]   cpu_tag;
  logic [s_index-1:0] cpu_index;

  assign cpu_tag   = cpu_address[31 -: s_tag];
  assign cpu_index = cpu_address[s_offset +: s_index];
  assign req       = cpu_read | cpu_write;
  assign hit       = valid_out && (tag_out == cpu_tag);

  always_comb begin
    state_d      = state_q;
    refill_d     = refill_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    cpu_resp     = 1'b0;
    array_read   = req;
    array_index  = cpu_index;
    tag_load     = 1'b0;
    valid_load   = 1'b0;
    dirty_load   = 1'b0;
    dirty_in     = 1'b0;
    data_load    = 1'b0;
    data_sel     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'h0;

    case (state_q)
      CHECK: begin
        if (req) begin
          if (hit) begin
            cpu_resp = 1'b1;
            // The replay after a fill is not a genuine hit
            hit_inc  = !refill_q;
            refill_d = 1'b0;
            if (cpu_write) begin
              data_load  = 1'b1;
              dirty_load = 1'b1;
              dirty_in   = 1'b1;
            end
          end else begin
            miss_inc = 1'b1;
            state_d  = (valid_out && dirty_out) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, cpu_index, {s_offset{1'b0}}};
        if (pmem_resp) begin
          state_d = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_align(cpu_address, s_offset);
        if (pmem_resp) begin
          data_load  = 1'b1;
          data_sel   = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          refill_d   = 1'b1;
          state_d    = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase

    // Reset silences every strobe immediately, including mid-transfer
    if (!rst_n) begin
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      cpu_resp     = 1'b0;
      array_read   = 1'b0;
      array_index  = '0;
      tag_load     = 1'b0;
      valid_load   = 1'b0;
      dirty_load   = 1'b0;
      dirty_in     = 1'b0;
      data_load    = 1'b0;
      data_sel     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CHECK;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
    end
  end

  sat_counter #(.width(cnt_width)) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.width(cnt_width)) u_miss_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control with tag/valid/dirty array and pmem models
module tb_cache_control;
  import cache_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_address = 32'h0;
  logic        pmem_resp = 1'b0;

  logic              cpu_resp, array_read, tag_load, valid_load, dirty_load, dirty_in;
  logic              data_load, data_sel, pmem_read, pmem_write;
  logic [S_INDEX-1:0] array_index;
  logic [31:0]       pmem_address;
  logic [15:0]       hit_count, miss_count;
  logic [S_TAG-1:0]  tag_out;
  logic              valid_out, dirty_out;

  logic              s_cpu_resp, s_array_read, s_tag_load, s_valid_load, s_dirty_load, s_dirty_in;
  logic              s_data_load, s_data_sel, s_pmem_read, s_pmem_write;
  logic [S_INDEX-1:0] s_array_index;
  logic [31:0]       s_pmem_address;
  logic [3:0]        s_hit_count, s_miss_count;

  logic [S_TAG-1:0] m_tag [8];
  logic             m_vld [8];
  logic             m_drt [8];

  assign tag_out   = m_tag[array_index];
  assign valid_out = m_vld[array_index];
  assign dirty_out = m_drt[array_index];

  always #5 clk = ~clk;

  cache_control u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_resp(cpu_resp), .array_read(array_read),
    .array_index(array_index), .tag_out(tag_out), .valid_out(valid_out),
    .dirty_out(dirty_out), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .data_load(data_load),
    .data_sel(data_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Identical twin with 4-bit counters; same inputs, so same control behaviour
  cache_control #(.cnt_width(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_resp(s_cpu_resp), .array_read(s_array_read),
    .array_index(s_array_index), .tag_out(tag_out), .valid_out(valid_out),
    .dirty_out(dirty_out), .tag_load(s_tag_load), .valid_load(s_valid_load),
    .dirty_load(s_dirty_load), .dirty_in(s_dirty_in), .data_load(s_data_load),
    .data_sel(s_data_sel), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_address(s_pmem_address), .pmem_resp(pmem_resp),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int          lat;
    logic        miss;
    logic        dirty;
    logic [31:0] wb;
    logic [31:0] fa;
    int          hits;
    int          misses;
  } exp_t;

  exp_t exp_q[$];
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic run_req(input logic wr, input logic [31:0] addr, input int wlat, input int flat);
    exp_t e;
    int cyc, wcnt, fcnt;
    logic [31:0] wb_seen, fa_seen;
    logic unstable, overlap, done;
    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0] tg;
    logic tl, vl, dl, di;
    idx = addr[S_OFFSET +: S_INDEX];
    tg  = addr[31 -: S_TAG];
    @(negedge clk);
    e.miss  = !(m_vld[idx] && m_tag[idx] == tg);
    e.dirty = e.miss && m_vld[idx] && m_drt[idx];
    e.lat   = !e.miss ? 0 : (e.dirty ? wlat : 0) + flat + 1;
    e.wb    = e.dirty ? {m_tag[idx], idx, 5'b0} : 32'h0;
    e.fa    = e.miss ? {addr[31:5], 5'b0} : 32'h0;
    if (e.miss) exp_misses++;
    else exp_hits++;
    e.hits   = exp_hits;
    e.misses = exp_misses;
    exp_q.push_back(e);
    cpu_read = !wr; cpu_write = wr; cpu_address = addr;
    cyc = 0; wcnt = 0; fcnt = 0; wb_seen = 0; fa_seen = 0;
    unstable = 0; overlap = 0; done = 0;
    while (!done && cyc < 64) begin
      #1;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap = 1;
      if (pmem_write) begin
        if (wcnt == 0) wb_seen = pmem_address;
        else if (pmem_address !== wb_seen) unstable = 1;
        wcnt++;
        pmem_resp = (wcnt == wlat);
      end else if (pmem_read) begin
        if (fcnt == 0) fa_seen = pmem_address;
        else if (pmem_address !== fa_seen) unstable = 1;
        fcnt++;
        pmem_resp = (fcnt == flat);
      end
      #1;
      if (pmem_resp && pmem_read)
        check("fill_strobes", {data_load, data_sel, tag_load, valid_load, dirty_load, dirty_in}, 6'b111110);
      if (cpu_resp) begin
        check("resp_strobes", {data_load, data_sel, dirty_load, dirty_in, pmem_read, pmem_write},
              wr ? 6'b101100 : 6'b000000);
        done = 1;
      end
      tl = tag_load; vl = valid_load; dl = dirty_load; di = dirty_in;
      @(posedge clk);
      if (tl) m_tag[idx] = tg;
      if (vl) m_vld[idx] = 1'b1;
      if (dl) m_drt[idx] = di;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0; pmem_resp = 1'b0;
    e = exp_q.pop_front();
    check("resp_seen", 32'(done), 1);
    check("latency", cyc, e.lat);
    check("hit_count", 32'(hit_count), e.hits);
    check("miss_count", 32'(miss_count), e.misses);
    check("sat_hit_count", 32'(s_hit_count), (e.hits > 15) ? 15 : e.hits);
    if (e.miss) begin
      check("fill_addr", fa_seen, e.fa);
      check("wb_addr", wb_seen, e.wb);
      check("pmem_stable", 32'(unstable), 0);
      check("pmem_excl", 32'(overlap), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_tag[i] = '0; m_vld[i] = 1'b0; m_drt[i] = 1'b0;
    end
    cpu_read = 1'b1;
    cpu_address = 32'h40;
    #12;
    check("rst_array_read", 32'(array_read), 0);
    check("rst_cpu_resp", 32'(cpu_resp), 0);
    check("rst_pmem", {pmem_read, pmem_write, pmem_address[29:0]}, 0);
    check("rst_counts", {hit_count, miss_count}, 0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b0, 32'h0000_0040, 2, 3);
    run_req(1'b0, 32'h0000_0044, 1, 1);
    run_req(1'b1, 32'h0000_0048, 1, 1);
    run_req(1'b0, 32'h0000_0140, 2, 3);
    run_req(1'b1, 32'h0000_0240, 1, 1);
    for (int i = 0; i < 12; i++) begin
      run_req(1'($urandom_range(0, 1)),
              (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 7) * 4),
              $urandom_range(1, 3), $urandom_range(1, 3));
    end
    run_req(1'b0, 32'h0000_0044, 1, 1);
    for (int i = 0; i < 20; i++) run_req(1'b0, 32'h0000_0044, 1, 1);

    @(negedge clk);
    cpu_read = 1'b1;
    cpu_address = 32'h8000_00E0;
    for (int k = 0; k < 20; k++) begin
      #1;
      pmem_resp = pmem_write;
      if (pmem_read) break;
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_fill_entered", 32'(pmem_read), 1);
    pmem_resp = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pmem_read", 32'(pmem_read), 0);
    check("rst_mid_loads", {data_load, tag_load, valid_load, dirty_load}, 0);
    check("rst_mid_counts", {hit_count, miss_count}, 0);
    check("rst_mid_resp", 32'(cpu_resp), 0);
    @(negedge clk);
    cpu_read = 1'b0;
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    run_req(1'b0, 32'h0000_0044, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
